// File: rtl/ncl_sync_dr_tx_if.sv
// Bus between a clocked valid/ready source and an NCL dual-rail pipeline.
// The master side is the source and the receiver; the slave side is the transmitter.
interface ncl_sync_dr_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d_t;
  logic [WIDTH-1:0] d_f;
  logic             ko;

  modport master (
    output in_data, in_valid, ko,
    input  in_ready, d_t, d_f
  );

  modport slave (
    input  in_data, in_valid, ko,
    output in_ready, d_t, d_f
  );
endinterface

// File: rtl/ncl_sync_dr_tx.sv
// Clocked valid/ready to NCL dual-rail transmitter, paced by a synchronised ko.
// Optional stall watchdog on err is built when NCL_TX_TIMEOUT_EN is defined.
module ncl_sync_dr_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            rst,
  ncl_sync_dr_tx_if.slave bus,
  output logic            busy,
  output logic            err
);

  localparam logic [1:0] S_NULL  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("ncl_sync_dr_tx: SYNC_STAGES or TIMEOUT out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ko_s;
  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic [WIDTH-1:0]       d_t_q, d_f_q;
  logic [WIDTH-1:0]       d_t_d, d_f_d;

  // Dual-rail encode: one-hot per pair in DATA, all zero in NULL, never 11.
  function automatic logic [2*WIDTH-1:0] dr_encode(input logic data_phase,
                                                   input logic [WIDTH-1:0] w);
    dr_encode = data_phase ? {w, ~w} : '0;
  endfunction

  assign ko_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_NULL:  if (ko_s) state_d = S_READY;
      S_READY: begin
        if (bus.in_valid) begin
          hold_d  = bus.in_data;
          state_d = S_DATA;
        end
      end
      S_DATA:  if (!ko_s) state_d = S_NULL;
      default: state_d = S_NULL;
    endcase
    {d_t_d, d_f_d} = dr_encode(state_d == S_DATA, hold_d);
  end

  // Rails come from the next state so DATA appears on all pairs one edge after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_NULL;
      d_t_q   <= '0;
      d_f_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.ko};
      state_q <= state_d;
      d_t_q   <= d_t_d;
      d_f_q   <= d_f_d;
    end
  end

  // Hold register only loads on accept, so it stays frozen through DATA.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign bus.d_t      = d_t_q;
  assign bus.d_f      = d_f_q;
  assign bus.in_ready = (state_q == S_READY);
  assign busy         = (state_q != S_READY);

`ifdef NCL_TX_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Counts consecutive cycles waiting on ko; READY waits on the source, not the pipeline.
  always_comb begin
    cnt_d = sat_inc(cnt_q);
    if ((state_d != state_q) || (state_q == S_READY)) cnt_d = '0;
    err_d = err_q | (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_sync_dr_tx.sv
// Bench for ncl_sync_dr_tx: directed token table, reset and wrong-phase sequences,
// and a random stream decoded by a behavioural NCL receiver.
module tb_ncl_sync_dr_tx;
  localparam int W     = 8;
  localparam int SS    = 2;
  localparam int TO    = 16;
  localparam int NRAND = 256;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_t;
    logic [W-1:0] exp_f;
    int           ko_dly;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;
  logic ko_man  = 1'b1;
  logic ko_rx   = 1'b1;
  logic rx_auto = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] rx_q[$];

  ncl_sync_dr_tx_if #(.WIDTH(W)) bus ();
  assign bus.ko = rx_auto ? ko_rx : ko_man;

  ncl_sync_dr_tx #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ko has just risen in NULL: in_ready must appear after exactly SS+1 edges.
  task automatic ready_after_ko(input string name);
    for (int j = 1; j <= SS + 1; j++) begin
      step();
      chk(name, 32'(bus.in_ready), 32'(j == SS + 1));
      chk({name, "_rails"}, 32'({bus.d_t, bus.d_f}), 32'd0);
    end
  endtask

  // ko has just fallen in DATA: rails hold for SS edges, then go NULL.
  task automatic null_after_ko(input logic [W-1:0] exp_t, input logic [W-1:0] exp_f);
    for (int j = 1; j <= SS + 1; j++) begin
      step();
      chk("null_t", 32'(bus.d_t), (j == SS + 1) ? 32'd0 : 32'(exp_t));
      chk("null_f", 32'(bus.d_f), (j == SS + 1) ? 32'd0 : 32'(exp_f));
    end
  endtask

  task automatic send_token(input logic [W-1:0] data, input logic [W-1:0] exp_t,
                            input logic [W-1:0] exp_f, input int kdly);
    chk("ready_before_token", 32'(bus.in_ready), 32'd1);
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = ~data;
    chk("data_t", 32'(bus.d_t), 32'(exp_t));
    chk("data_f", 32'(bus.d_f), 32'(exp_f));
    chk("ready_low_in_data", 32'(bus.in_ready), 32'd0);
    chk("busy_in_data", 32'(busy), 32'd1);
    for (int k = 0; k < kdly; k++) begin
      step();
      chk("data_hold_t", 32'(bus.d_t), 32'(exp_t));
    end
    ko_man = 1'b0;
    null_after_ko(exp_t, exp_f);
    ko_man = 1'b1;
    ready_after_ko("ready_after_null");
  endtask

  // Rail monitor plus behavioural NCL receiver with random ack delay.
  initial begin : monitor
    logic [W-1:0] t, f;
    logic [W-1:0] prev_t;
    bit prev_data, is_data, is_null, bad;
    int dly;
    prev_t    = '0;
    prev_data = 1'b0;
    dly       = 0;
    forever begin
      @(posedge clk);
      #2;
      t = bus.d_t;
      f = bus.d_f;
      is_null = ((t | f) == '0);
      is_data = ((t ^ f) == '1) && ((t & f) == '0);
      bad = $isunknown({t, f}) || ((t & f) != '0) || (!is_null && !is_data)
            || (prev_data && is_data && (t != prev_t));
      chk("rail_encoding", 32'(bad), 32'd0);
`ifndef NCL_TX_TIMEOUT_EN
      chk("err_tied_off", 32'(err), 32'd0);
`endif
      prev_data = is_data && !bad;
      prev_t    = t;
      if (!rx_auto) begin
        ko_rx = ko_man;
      end else if (is_data && ko_rx) begin
        if (dly == 0) begin
          rx_q.push_back(t);
          ko_rx = 1'b0;
          dly   = int'($urandom_range(0, 3));
        end else dly--;
      end else if (is_null && !ko_rx) begin
        if (dly == 0) begin
          ko_rx = 1'b1;
          dly   = int'($urandom_range(0, 3));
        end else dly--;
      end
    end
  end

  initial begin : main
    vec_t tbl[6];
    logic [W-1:0] w[NRAND];
    int idx, cyc, base;
    bit acc;

    tbl[0] = '{8'hA5, 8'hA5, 8'h5A, 3};
    tbl[1] = '{8'h00, 8'h00, 8'hFF, 1};
    tbl[2] = '{8'hFF, 8'hFF, 8'h00, 0};
    tbl[3] = '{8'h3C, 8'h3C, 8'hC3, 2};
    tbl[4] = '{8'h01, 8'h01, 8'hFE, 4};
    tbl[5] = '{8'h80, 8'h80, 8'h7F, 3};

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    ko_man       = 1'b1;
    rst          = 1'b1;
    repeat (2) step();
    chk("reset_d_t", 32'(bus.d_t), 32'd0);
    chk("reset_d_f", 32'(bus.d_f), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    ready_after_ko("ready_after_reset");
    chk("busy_in_ready", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++)
      send_token(tbl[i].data, tbl[i].exp_t, tbl[i].exp_f, tbl[i].ko_dly);

    // Reset in the middle of a DATA wavefront.
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("midrst_data_t", 32'(bus.d_t), 32'hFF);
    rst    = 1'b1;
    ko_man = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_rails", 32'({bus.d_t, bus.d_f}), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_err", 32'(err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_ready_while_ko_low", 32'(bus.in_ready), 32'd0);
    end
    ko_man = 1'b1;
    ready_after_ko("ready_after_midrst");
    send_token(8'h5C, 8'h5C, 8'hA3, 2);

    // ko stays in the wrong phase during DATA while the source keeps changing in_data.
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      bus.in_data = W'($urandom);
      chk("wrongphase_t", 32'(bus.d_t), 32'hFF);
      chk("wrongphase_f", 32'(bus.d_f), 32'h00);
      chk("wrongphase_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    ko_man = 1'b0;
    null_after_ko(8'hFF, 8'h00);
    ko_man = 1'b1;
    ready_after_ko("ready_after_wrongphase");

    // Random back-to-back stream through the behavioural receiver.
    for (int i = 0; i < NRAND; i++) w[i] = W'($urandom);
    base    = rx_q.size();
    rx_auto = 1'b1;
    idx     = 0;
    cyc     = 0;
    bus.in_data  = w[0];
    bus.in_valid = 1'b1;
    while (idx < NRAND && cyc < NRAND * 24) begin
      acc = bus.in_ready;
      step();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < NRAND) bus.in_data = w[idx];
      end
    end
    bus.in_valid = 1'b0;
    chk("rand_all_accepted", 32'(idx), 32'(NRAND));
    cyc = 0;
    while ((rx_q.size() - base < NRAND || !bus.in_ready) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("rand_rx_count", 32'(rx_q.size() - base), 32'(NRAND));
    for (int i = 0; i < NRAND; i++)
      if (base + i < rx_q.size()) chk("rand_word", 32'(rx_q[base + i]), 32'(w[i]));
    ko_man  = 1'b1;
    rx_auto = 1'b0;
    chk("ready_after_rand", 32'(bus.in_ready), 32'd1);

`ifdef NCL_TX_TIMEOUT_EN
    chk("err_pre", 32'(err), 32'd0);
    bus.in_data  = 8'h96;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("err_at_data", 32'(err), 32'd0);
    for (int k = 1; k <= TO + 1; k++) begin
      step();
      chk("err_timing", 32'(err), 32'(k == TO + 1));
    end
    ko_man = 1'b0;
    null_after_ko(8'h96, 8'h69);
    ko_man = 1'b1;
    ready_after_ko("ready_after_timeout");
    chk("err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    ready_after_ko("ready_after_err_rst");
    chk("err_stays_clear", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

endmodule
